// File: rtl/instr_controller.sv
// Instruction sequencer: pulls 16-bit instructions byte-wise from an RX FIFO and
// drives the unified buffer, TX FIFO and systolic array with registered strobes.
module instr_controller #(
  parameter int OPCODE_W = 3,
  parameter int ADDR_W   = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_empty,
  input  logic [7:0]        rx_rdata,
  output logic              rx_re,
  input  logic              tx_full,
  output logic              tx_we,
  output logic [7:0]        tx_wdata,
  output logic              ub_we,
  output logic              ub_re,
  output logic [ADDR_W-1:0] ub_addr,
  output logic [15:0]       ub_wdata,
  input  logic [15:0]       ub_rdata,
  output logic              arr_start,
  input  logic              arr_done,
  input  logic [15:0]       arr_result,
  output logic              arr_load,
  output logic [15:0]       arr_load_data,
  output logic              busy,
  output logic              halted,
  output logic              illegal_op
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_RD_LO    = 4'd1;
  localparam logic [3:0] S_RD_HI    = 4'd2;
  localparam logic [3:0] S_DECODE   = 4'd3;
  localparam logic [3:0] S_DATA_LO  = 4'd4;
  localparam logic [3:0] S_DATA_HI  = 4'd5;
  localparam logic [3:0] S_EXEC     = 4'd6;
  localparam logic [3:0] S_UB_WAIT  = 4'd7;
  localparam logic [3:0] S_TX_PUSH  = 4'd8;
  localparam logic [3:0] S_RUN_WAIT = 4'd9;
  localparam logic [3:0] S_HALTED   = 4'd10;

  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_FETCH = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_RUN   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(5);

  logic [3:0]                 state;
  logic [1:0]                 rd_ph;
  logic [7:0]                 lo_q;
  logic [15:0]                word_w;
  logic [15:0]                data_q;
  logic [ADDR_W+OPCODE_W+1:0] instr_q;
  logic [OPCODE_W-1:0]        in_op, op_q;
  logic                       in_bot, in_imm, bot_q, imm_q;
  logic [ADDR_W-1:0]          in_addr, addr_q;

  function automatic logic [3:0] rd_next(input logic [3:0] s);
    case (s)
      S_RD_LO:   return S_RD_HI;
      S_RD_HI:   return S_DECODE;
      S_DATA_LO: return S_DATA_HI;
      default:   return S_EXEC;
    endcase
  endfunction

  function automatic logic [7:0] sel_byte(input logic [15:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

  // Only the decoded fields of the instruction word are kept: {addr, imm, bot, opcode}
  assign word_w  = {rx_rdata, lo_q};
  assign in_op   = instr_q[OPCODE_W-1:0];
  assign in_bot  = instr_q[OPCODE_W];
  assign in_imm  = instr_q[OPCODE_W+1];
  assign in_addr = instr_q[OPCODE_W+2 +: ADDR_W];
  assign busy    = (state != S_IDLE) && (state != S_HALTED);

  // Byte/word capture and decode latches
  always_ff @(posedge clk) begin
    if (rd_ph == 2'd2) begin
      case (state)
        S_RD_LO, S_DATA_LO: lo_q <= rx_rdata;
        S_RD_HI:   instr_q <= {word_w[7 +: ADDR_W], word_w[4], word_w[3], word_w[OPCODE_W-1:0]};
        S_DATA_HI: data_q  <= word_w;
        default: ;
      endcase
    end
    if (state == S_DECODE) begin
      op_q   <= in_op;
      bot_q  <= in_bot;
      imm_q  <= in_imm;
      addr_q <= in_addr;
    end
  end

  // Control FSM; every strobe defaults low so each assertion is a one-cycle pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      rd_ph         <= 2'd0;
      rx_re         <= 1'b0;
      tx_we         <= 1'b0;
      ub_we         <= 1'b0;
      ub_re         <= 1'b0;
      arr_start     <= 1'b0;
      arr_load      <= 1'b0;
      halted        <= 1'b0;
      illegal_op    <= 1'b0;
      ub_addr       <= '0;
      ub_wdata      <= '0;
      tx_wdata      <= '0;
      arr_load_data <= '0;
    end else begin
      rx_re     <= 1'b0;
      tx_we     <= 1'b0;
      ub_we     <= 1'b0;
      ub_re     <= 1'b0;
      arr_start <= 1'b0;
      arr_load  <= 1'b0;
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state  <= S_RD_LO;
            halted <= 1'b0;
          end
        end
        // rd_ph: 0 = request when data available, 1 = pop in flight, 2 = data valid
        S_RD_LO, S_RD_HI, S_DATA_LO, S_DATA_HI: begin
          case (rd_ph)
            2'd0: begin
              if (!rx_empty) begin
                rx_re <= 1'b1;
                rd_ph <= 2'd1;
              end
            end
            2'd1:    rd_ph <= 2'd2;
            default: begin
              rd_ph <= 2'd0;
              state <= rd_next(state);
            end
          endcase
        end
        S_DECODE: begin
          case (in_op)
            OP_STORE: state <= in_imm ? S_DATA_LO : S_EXEC;
            OP_FETCH, OP_LOAD: begin
              ub_re   <= 1'b1;
              ub_addr <= in_addr;
              state   <= S_UB_WAIT;
            end
            OP_RUN:  state <= S_EXEC;
            OP_HALT: begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end
            OP_NOP:  state <= S_RD_LO;
            default: begin
              illegal_op <= 1'b1;
              state      <= S_RD_LO;
            end
          endcase
        end
        S_EXEC: begin
          case (op_q)
            OP_STORE: begin
              ub_we    <= 1'b1;
              ub_addr  <= addr_q;
              ub_wdata <= imm_q ? data_q : arr_result;
              state    <= S_RD_LO;
            end
            OP_RUN: begin
              arr_start <= 1'b1;
              state     <= S_RUN_WAIT;
            end
            OP_LOAD: begin
              arr_load      <= 1'b1;
              arr_load_data <= ub_rdata;
              state         <= S_RD_LO;
            end
            default: state <= S_RD_LO;
          endcase
        end
        S_UB_WAIT: state <= (op_q == OP_FETCH) ? S_TX_PUSH : S_EXEC;
        S_TX_PUSH: begin
          if (!tx_full) begin
            tx_we    <= 1'b1;
            tx_wdata <= sel_byte(ub_rdata, bot_q);
            state    <= S_RD_LO;
          end
        end
        S_RUN_WAIT: begin
          if (arr_done) state <= S_RD_LO;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_controller.sv
// Directed bench for instr_controller with FIFO/buffer models and a scoreboard
// of expected buffer writes, TX bytes and array loads.
module tb_instr_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        rx_empty = 1'b1;
  logic [7:0]  rx_rdata = 8'd0;
  logic        rx_re;
  logic        tx_full = 1'b0;
  logic        tx_we;
  logic [7:0]  tx_wdata;
  logic        ub_we, ub_re;
  logic [8:0]  ub_addr;
  logic [15:0] ub_wdata;
  logic [15:0] ub_rdata = 16'd0;
  logic        arr_start;
  logic        arr_done = 1'b0;
  logic [15:0] arr_result = 16'd0;
  logic        arr_load;
  logic [15:0] arr_load_data;
  logic        busy, halted, illegal_op;

  instr_controller #(.OPCODE_W(3), .ADDR_W(9)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rx_empty(rx_empty), .rx_rdata(rx_rdata), .rx_re(rx_re),
    .tx_full(tx_full), .tx_we(tx_we), .tx_wdata(tx_wdata),
    .ub_we(ub_we), .ub_re(ub_re), .ub_addr(ub_addr), .ub_wdata(ub_wdata), .ub_rdata(ub_rdata),
    .arr_start(arr_start), .arr_done(arr_done), .arr_result(arr_result),
    .arr_load(arr_load), .arr_load_data(arr_load_data),
    .busy(busy), .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  a;
    logic [15:0] d;
  } ubw_t;

  logic [7:0]  rxq[$];
  ubw_t        ubq[$];
  logic [7:0]  txq[$];
  logic [15:0] ldq[$];
  logic [15:0] mem [0:511];
  ubw_t        exp_w;

  int errors = 0, checks = 0;
  int rx_re_cnt = 0, ub_we_cnt = 0, ub_re_cnt = 0, tx_we_cnt = 0, arr_start_cnt = 0, arr_load_cnt = 0;
  int onehot_err = 0, full_err = 0, rx_underflow = 0;
  int base, n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {6'd0, rx_re, tx_we, ub_we, ub_re, arr_start, arr_load, busy, halted, illegal_op,
            ub_addr, ub_wdata, tx_wdata, arr_load_data};
  endfunction

  // RX FIFO: data appears the cycle after rx_re
  always @(posedge clk) begin
    if (rx_re) begin
      if (rxq.size() == 0) rx_underflow++;
      else rx_rdata <= rxq.pop_front();
    end
  end
  always @(negedge clk) rx_empty = (rxq.size() == 0);

  // Unified buffer, one-cycle read latency
  always @(posedge clk) begin
    if (ub_we) mem[ub_addr] <= ub_wdata;
    if (ub_re) ub_rdata <= mem[ub_addr];
  end

  // Output monitor / scoreboard consumer
  always @(negedge clk) begin
    if (rst) begin
      if ($countones({ub_we, ub_re, tx_we, arr_start, arr_load}) > 1) onehot_err++;
      if (tx_we && tx_full) full_err++;
      if (rx_re) rx_re_cnt++;
      if (ub_re) ub_re_cnt++;
      if (arr_start) arr_start_cnt++;
      if (ub_we) begin
        ub_we_cnt++;
        check("ub_we_pending", 64'(ubq.size() > 0), 64'd1);
        if (ubq.size() > 0) begin
          exp_w = ubq.pop_front();
          check("ub_addr", 64'(ub_addr), 64'(exp_w.a));
          check("ub_wdata", 64'(ub_wdata), 64'(exp_w.d));
        end
      end
      if (tx_we) begin
        tx_we_cnt++;
        check("tx_we_pending", 64'(txq.size() > 0), 64'd1);
        if (txq.size() > 0) check("tx_wdata", 64'(tx_wdata), 64'(txq.pop_front()));
      end
      if (arr_load) begin
        arr_load_cnt++;
        check("arr_load_pending", 64'(ldq.size() > 0), 64'd1);
        if (ldq.size() > 0) check("arr_load_data", 64'(arr_load_data), 64'(ldq.pop_front()));
      end
    end
  end

  task automatic push_word(input logic [15:0] w);
    rxq.push_back(w[7:0]);
    rxq.push_back(w[15:8]);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int k = 0;
    while (halted !== 1'b1 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, 64'(halted), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Preloaded FIFO, no start: nothing happens
    push_word(16'h0005);
    push_word(16'h0004);
    repeat (100) @(posedge clk);
    #1;
    check("idle_no_rx_re", 64'(rx_re_cnt), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_outputs", outs(), 64'd0);

    // NOP then HALT
    pulse_start();
    wait_halt("nop_halt_reached");
    check("nop_halt_rx_re", 64'(rx_re_cnt), 64'd4);
    check("nop_halt_busy", 64'(busy), 64'd0);
    check("nop_halt_other_strobes", 64'(ub_we_cnt + ub_re_cnt + tx_we_cnt + arr_start_cnt + arr_load_cnt), 64'd0);

    // STORE immediate
    push_word(16'h0910);
    push_word(16'hADDE);
    push_word(16'h0004);
    ubq.push_back('{a: 9'h012, d: 16'hADDE});
    pulse_start();
    check("halted_clears_on_start", 64'(halted), 64'd0);
    wait_halt("store_imm_halt");
    check("store_imm_count", 64'(ub_we_cnt), 64'd1);
    check("store_imm_rx_re", 64'(rx_re_cnt), 64'd10);

    // FETCH low and high byte with TX FIFO full for 20 cycles
    tx_full = 1'b1;
    push_word(16'h0901);
    push_word(16'h0909);
    push_word(16'h0004);
    txq.push_back(8'hDE);
    txq.push_back(8'hAD);
    pulse_start();
    repeat (20) @(posedge clk);
    #1;
    check("fetch_held_while_full", 64'(tx_we_cnt), 64'd0);
    check("fetch_ub_re_issued", 64'(ub_re_cnt), 64'd1);
    check("fetch_busy_while_full", 64'(busy), 64'd1);
    tx_full = 1'b0;
    wait_halt("fetch_halt");
    check("fetch_tx_count", 64'(tx_we_cnt), 64'd2);

    // RUN with arr_done 50 cycles after arr_start; a stray start is ignored
    base = arr_start_cnt;
    push_word(16'h0002);
    push_word(16'h0004);
    pulse_start();
    n = 0;
    while (arr_start_cnt == base && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("run_arr_start", 64'(arr_start_cnt - base), 64'd1);
    base = rx_re_cnt;
    repeat (24) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    check("run_no_rx_before_done", 64'(rx_re_cnt), 64'(base));
    check("run_busy", 64'(busy), 64'd1);
    arr_done = 1'b1;
    @(posedge clk); #1 arr_done = 1'b0;
    wait_halt("run_halt");
    check("run_single_start", 64'(arr_start_cnt), 64'd1);
    check("run_rx_after_done", 64'(rx_re_cnt), 64'(base + 2));

    // LOAD, STORE from array result, NOP
    arr_result = 16'h1234;
    push_word(16'h0903);
    push_word(16'h0A00);
    push_word(16'h0005);
    push_word(16'h0004);
    ldq.push_back(16'hADDE);
    ubq.push_back('{a: 9'h014, d: 16'h1234});
    pulse_start();
    wait_halt("load_store_halt");
    check("load_count", 64'(arr_load_cnt), 64'd1);
    check("store_arr_count", 64'(ub_we_cnt), 64'd2);
    check("no_illegal_yet", 64'(illegal_op), 64'd0);

    // Illegal opcode, then reset while stalled in RD_HI
    push_word(16'h0007);
    rxq.push_back(8'h05);
    base = rx_re_cnt;
    pulse_start();
    n = 0;
    while (rx_re_cnt < base + 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("illegal_set", 64'(illegal_op), 64'd1);
    check("illegal_rx_re", 64'(rx_re_cnt), 64'(base + 3));
    check("stalled_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_outputs", outs(), 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", outs(), 64'd0);
    push_word(16'h0004);
    base = rx_re_cnt;
    repeat (30) @(posedge clk);
    #1;
    check("post_reset_no_rx", 64'(rx_re_cnt), 64'(base));
    check("post_reset_busy", 64'(busy), 64'd0);
    pulse_start();
    wait_halt("post_reset_halt");
    check("post_reset_rx_re", 64'(rx_re_cnt), 64'(base + 2));
    check("post_reset_illegal", 64'(illegal_op), 64'd0);

    // Global invariants
    check("strobe_onehot", 64'(onehot_err), 64'd0);
    check("tx_we_while_full", 64'(full_err), 64'd0);
    check("rx_underflow", 64'(rx_underflow), 64'd0);
    check("scoreboard_drained", 64'(ubq.size() + txq.size() + ldq.size()), 64'd0);
    check("total_ub_we", 64'(ub_we_cnt), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
